// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Defines the FSM states, the PC source codes and the latch-control bundle.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_REDIRECT = 2'd2
    } hz_state_e;

    localparam logic [1:0] PC_SEL_PC4    = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_MTVEC  = 2'd2;
    localparam logic [1:0] PC_SEL_MEPC   = 2'd3;

    typedef struct packed {
        logic       en_if;
        logic       en_ifid;
        logic       en_idex;
        logic       en_exmem;
        logic       en_memwb;
        logic       flush_ifid;
        logic       flush_idex;
        logic       flush_exmem;
        logic [1:0] pc_sel;
        logic       trap_commit;
    } latch_ctrl_t;

    // Every latch advances, nothing is flushed, fetch continues at PC+4.
    localparam latch_ctrl_t CTRL_RUN_DEFAULT = '{
        en_if: 1'b1, en_ifid: 1'b1, en_idex: 1'b1, en_exmem: 1'b1, en_memwb: 1'b1,
        flush_ifid: 1'b0, flush_idex: 1'b0, flush_exmem: 1'b0,
        pc_sel: PC_SEL_PC4, trap_commit: 1'b0
    };

    // Whole pipeline frozen while data memory is busy.
    localparam latch_ctrl_t CTRL_FROZEN = '{
        en_if: 1'b0, en_ifid: 1'b0, en_idex: 1'b0, en_exmem: 1'b0, en_memwb: 1'b0,
        flush_ifid: 1'b0, flush_idex: 1'b0, flush_exmem: 1'b0,
        pc_sel: PC_SEL_PC4, trap_commit: 1'b0
    };

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of pipeline hazard inputs and latch-control outputs.
// The pipeline side uses master; the sequencer uses slave.
interface pipe_hazard_ctrl_if;
    logic [4:0] rs1_ID;
    logic [4:0] rs2_ID;
    logic       rs1_used_ID;
    logic       rs2_used_ID;
    logic [4:0] rd_EX;
    logic       mem_r_EX;
    logic       redirect_EX;
    logic [1:0] exp_vector_MEM;
    logic       mret_MEM;
    logic       isFlushed_MEM;
    logic       dmem_busy;

    logic       en_IF;
    logic       en_IFID;
    logic       flush_IFID;
    logic       en_IDEX;
    logic       flush_IDEX;
    logic       en_EXMEM;
    logic       flush_EXMEM;
    logic       en_MEMWB;
    logic [1:0] pc_sel;
    logic       trap_commit;

    modport master (
        output rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_EX, mem_r_EX,
               redirect_EX, exp_vector_MEM, mret_MEM, isFlushed_MEM, dmem_busy,
        input  en_IF, en_IFID, flush_IFID, en_IDEX, flush_IDEX, en_EXMEM,
               flush_EXMEM, en_MEMWB, pc_sel, trap_commit
    );

    modport slave (
        input  rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_EX, mem_r_EX,
               redirect_EX, exp_vector_MEM, mret_MEM, isFlushed_MEM, dmem_busy,
        output en_IF, en_IFID, flush_IFID, en_IDEX, flush_IDEX, en_EXMEM,
               flush_EXMEM, en_MEMWB, pc_sel, trap_commit
    );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and redirect performance counters.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB latches: stalls,
// flushes, PC source selection, and saturating stall/redirect counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REDIRECT_BUBBLES = 1,
    parameter int unsigned CNT_W            = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hazard_ctrl_if.slave hz,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam logic [3:0] BUBBLES_INIT = 4'(REDIRECT_BUBBLES);

    hz_state_e   state_q;
    hz_state_e   state_d;
    logic [3:0]  bubble_q;
    logic [3:0]  bubble_d;
    latch_ctrl_t ctrl;
    logic        stall_inc;
    logic        flush_inc;
    logic        trap_evt;
    logic        mret_evt;
    logic        rs1_hit;
    logic        rs2_hit;
    logic        load_use;

    // A flushed bubble in MEM can never raise a trap or return.
    assign trap_evt = (hz.exp_vector_MEM != 2'b00) && !hz.isFlushed_MEM;
    assign mret_evt = hz.mret_MEM && !hz.isFlushed_MEM;

    assign rs1_hit  = hz.rs1_used_ID && (hz.rs1_ID == hz.rd_EX);
    assign rs2_hit  = hz.rs2_used_ID && (hz.rs2_ID == hz.rd_EX);
    assign load_use = hz.mem_r_EX && (hz.rd_EX != 5'd0) && (rs1_hit || rs2_hit);

    always_comb begin
        state_d   = state_q;
        bubble_d  = bubble_q;
        ctrl      = CTRL_RUN_DEFAULT;
        stall_inc = 1'b0;
        flush_inc = 1'b0;

        if (!rst) begin
            case (state_q)
                ST_RUN: begin
                    if (trap_evt || mret_evt) begin
                        ctrl.flush_ifid  = 1'b1;
                        ctrl.flush_idex  = 1'b1;
                        ctrl.flush_exmem = 1'b1;
                        ctrl.pc_sel      = trap_evt ? PC_SEL_MTVEC : PC_SEL_MEPC;
                        ctrl.trap_commit = trap_evt;
                        flush_inc        = 1'b1;
                        if (BUBBLES_INIT != 4'd0) begin
                            state_d  = ST_REDIRECT;
                            bubble_d = BUBBLES_INIT;
                        end
                    end else if (hz.dmem_busy) begin
                        ctrl      = CTRL_FROZEN;
                        stall_inc = 1'b1;
                        state_d   = ST_MEM_WAIT;
                    end else if (hz.redirect_EX) begin
                        // The ID instruction is discarded, so any load-use is moot.
                        ctrl.flush_ifid = 1'b1;
                        ctrl.flush_idex = 1'b1;
                        ctrl.pc_sel     = PC_SEL_BRANCH;
                        flush_inc       = 1'b1;
                    end else if (load_use) begin
                        ctrl.en_if      = 1'b0;
                        ctrl.en_ifid    = 1'b0;
                        ctrl.flush_idex = 1'b1;
                        stall_inc       = 1'b1;
                    end
                end

                ST_MEM_WAIT: begin
                    if (hz.dmem_busy) begin
                        ctrl      = CTRL_FROZEN;
                        stall_inc = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end

                ST_REDIRECT: begin
                    if (hz.dmem_busy) begin
                        ctrl      = CTRL_FROZEN;
                        stall_inc = 1'b1;
                    end else begin
                        ctrl.en_if      = 1'b0;
                        ctrl.flush_ifid = 1'b1;
                        bubble_d        = bubble_q - 4'd1;
                        if (bubble_q <= 4'd1) begin
                            state_d = ST_RUN;
                        end
                    end
                end

                default: begin
                    state_d  = ST_RUN;
                    bubble_d = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            bubble_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            bubble_q <= bubble_d;
        end
    end

    assign hz.en_IF       = ctrl.en_if;
    assign hz.en_IFID     = ctrl.en_ifid;
    assign hz.flush_IFID  = ctrl.flush_ifid;
    assign hz.en_IDEX     = ctrl.en_idex;
    assign hz.flush_IDEX  = ctrl.flush_idex;
    assign hz.en_EXMEM    = ctrl.en_exmem;
    assign hz.flush_EXMEM = ctrl.flush_exmem;
    assign hz.en_MEMWB    = ctrl.en_memwb;
    assign hz.pc_sel      = ctrl.pc_sel;
    assign hz.trap_commit = ctrl.trap_commit;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_events)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int RB  = 2;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] flush_events;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: pending memory wait, remaining fetch bubbles, counters.
    bit m_waiting = 1'b0;
    int m_bubbles = 0;
    int m_stall   = 0;
    int m_flush   = 0;

    pipe_hazard_ctrl_if hz();

    pipe_hazard_ctrl #(.REDIRECT_BUBBLES(RB), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .hz           (hz),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    endtask

    task automatic idle();
        hz.rs1_ID         = 5'd1;
        hz.rs2_ID         = 5'd2;
        hz.rs1_used_ID    = 1'b0;
        hz.rs2_used_ID    = 1'b0;
        hz.rd_EX          = 5'd0;
        hz.mem_r_EX       = 1'b0;
        hz.redirect_EX    = 1'b0;
        hz.exp_vector_MEM = 2'b00;
        hz.mret_MEM       = 1'b0;
        hz.isFlushed_MEM  = 1'b0;
        hz.dmem_busy      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] r);
        hz.mem_r_EX    = 1'b1;
        hz.rd_EX       = r;
        hz.rs1_ID      = r;
        hz.rs1_used_ID = 1'b1;
    endtask

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge clk) begin
        logic [4:0]  e_en;
        logic [2:0]  e_fl;
        logic [1:0]  e_pc;
        logic        e_tc;
        logic [10:0] got;
        bit          s_inc;
        bit          f_inc;
        bit          trap;
        bit          mret;
        bit          lu;

        e_en  = 5'b11111;
        e_fl  = 3'b000;
        e_pc  = 2'd0;
        e_tc  = 1'b0;
        s_inc = 1'b0;
        f_inc = 1'b0;
        trap  = (hz.exp_vector_MEM != 2'b00) && !hz.isFlushed_MEM;
        mret  = hz.mret_MEM && !hz.isFlushed_MEM;
        lu    = hz.mem_r_EX && (hz.rd_EX != 5'd0) &&
                ((hz.rs1_used_ID && hz.rs1_ID == hz.rd_EX) ||
                 (hz.rs2_used_ID && hz.rs2_ID == hz.rd_EX));

        if (rst) begin
            m_waiting = 1'b0;
            m_bubbles = 0;
            m_stall   = 0;
            m_flush   = 0;
        end else if (m_waiting) begin
            if (hz.dmem_busy) begin e_en = 5'b00000; s_inc = 1'b1; end
            else m_waiting = 1'b0;
        end else if (m_bubbles > 0) begin
            if (hz.dmem_busy) begin e_en = 5'b00000; s_inc = 1'b1; end
            else begin
                e_en      = 5'b01111;
                e_fl      = 3'b100;
                m_bubbles = m_bubbles - 1;
            end
        end else if (trap || mret) begin
            e_fl      = 3'b111;
            e_pc      = trap ? 2'd2 : 2'd3;
            e_tc      = trap;
            f_inc     = 1'b1;
            m_bubbles = RB;
        end else if (hz.dmem_busy) begin
            e_en      = 5'b00000;
            s_inc     = 1'b1;
            m_waiting = 1'b1;
        end else if (hz.redirect_EX) begin
            e_fl  = 3'b110;
            e_pc  = 2'd1;
            f_inc = 1'b1;
        end else if (lu) begin
            e_en  = 5'b00111;
            e_fl  = 3'b010;
            s_inc = 1'b1;
        end

        got = {hz.en_IF, hz.en_IFID, hz.en_IDEX, hz.en_EXMEM, hz.en_MEMWB,
               hz.flush_IFID, hz.flush_IDEX, hz.flush_EXMEM, hz.pc_sel, hz.trap_commit};
        chk("model_ctrl", 32'(got), 32'({e_en, e_fl, e_pc, e_tc}));
        chk("model_stall_cycles", 32'(stall_cycles), m_stall);
        chk("model_flush_events", 32'(flush_events), m_flush);

        if (!rst) begin
            m_stall = (m_stall + int'(s_inc) > SAT) ? SAT : m_stall + int'(s_inc);
            m_flush = (m_flush + int'(f_inc) > SAT) ? SAT : m_flush + int'(f_inc);
        end
    end

    initial begin
        idle();
        #1 rst = 1'b1;
        #1;
        chk("reset_en_IF", hz.en_IF, 1);
        chk("reset_flush_IFID", hz.flush_IFID, 0);
        chk("reset_stall_cycles", stall_cycles, 0);
        tick();
        rst = 1'b0;

        // Load-use: exactly one bubble.
        set_load_use(5'd5);
        #1;
        chk("lu_en_IF", hz.en_IF, 0);
        chk("lu_en_IFID", hz.en_IFID, 0);
        chk("lu_flush_IDEX", hz.flush_IDEX, 1);
        chk("lu_en_EXMEM", hz.en_EXMEM, 1);
        tick();
        idle();
        #1;
        chk("lu_next_en_IF", hz.en_IF, 1);
        chk("lu_stall_cycles", stall_cycles, 1);

        // x0 destination never stalls.
        set_load_use(5'd0);
        #1;
        chk("x0_no_stall_en_IF", hz.en_IF, 1);
        tick();
        idle();

        // Taken branch overrides a simultaneous load-use.
        do_reset();
        set_load_use(5'd7);
        hz.redirect_EX = 1'b1;
        #1;
        chk("br_flush_IFID", hz.flush_IFID, 1);
        chk("br_flush_IDEX", hz.flush_IDEX, 1);
        chk("br_pc_sel", hz.pc_sel, 1);
        chk("br_en_IF", hz.en_IF, 1);
        tick();
        idle();
        #1;
        chk("br_flush_events", flush_events, 1);
        chk("br_stall_cycles", stall_cycles, 0);

        // Memory wait of three cycles.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            hz.dmem_busy = 1'b1;
            #1;
            chk("mw_en_IF", hz.en_IF, 0);
            chk("mw_en_MEMWB", hz.en_MEMWB, 0);
            tick();
        end
        idle();
        #1;
        chk("mw_resume_en_IF", hz.en_IF, 1);
        chk("mw_stall_cycles", stall_cycles, 3);

        // Trap followed by two fetch bubbles.
        do_reset();
        hz.exp_vector_MEM = 2'b01;
        #1;
        chk("trap_commit", hz.trap_commit, 1);
        chk("trap_pc_sel", hz.pc_sel, 2);
        chk("trap_flush_EXMEM", hz.flush_EXMEM, 1);
        chk("trap_en_MEMWB", hz.en_MEMWB, 1);
        tick();
        idle();
        #1;
        chk("trap_bubble1_en_IF", hz.en_IF, 0);
        chk("trap_bubble1_flush_IFID", hz.flush_IFID, 1);
        tick();
        chk("trap_bubble2_en_IF", hz.en_IF, 0);
        tick();
        chk("trap_done_en_IF", hz.en_IF, 1);
        chk("trap_flush_events", flush_events, 1);

        // Flushed MEM slot raises nothing.
        hz.exp_vector_MEM = 2'b01;
        hz.isFlushed_MEM  = 1'b1;
        #1;
        chk("flushed_trap_commit", hz.trap_commit, 0);
        chk("flushed_pc_sel", hz.pc_sel, 0);
        tick();
        idle();

        // Trap beats dmem_busy; then mret beats dmem_busy.
        hz.exp_vector_MEM = 2'b10;
        hz.dmem_busy      = 1'b1;
        #1;
        chk("trap_busy_pc_sel", hz.pc_sel, 2);
        chk("trap_busy_en_IF", hz.en_IF, 1);
        tick();
        idle();
        tick();
        tick();
        hz.mret_MEM  = 1'b1;
        hz.dmem_busy = 1'b1;
        #1;
        chk("mret_busy_pc_sel", hz.pc_sel, 3);
        chk("mret_trap_commit", hz.trap_commit, 0);
        tick();
        idle();

        // Asynchronous reset in the middle of REDIRECT.
        rst = 1'b1;
        #1;
        chk("rst_mid_en_IF", hz.en_IF, 1);
        chk("rst_mid_flush_IFID", hz.flush_IFID, 0);
        chk("rst_mid_flush_events", flush_events, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_after_en_IF", hz.en_IF, 1);

        // Stall counter saturation.
        tick();
        for (int i = 0; i < 20; i++) begin
            hz.dmem_busy = 1'b1;
            tick();
        end
        idle();
        #1;
        chk("sat_stall_cycles", stall_cycles, 15);

        // Randomized traffic checked by the per-cycle compare process.
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst               = ($urandom_range(0, 199) == 0);
            hz.rd_EX          = 5'($urandom_range(0, 31));
            hz.rs1_ID         = ($urandom_range(0, 2) == 0) ? hz.rd_EX : 5'($urandom_range(0, 31));
            hz.rs2_ID         = ($urandom_range(0, 2) == 0) ? hz.rd_EX : 5'($urandom_range(0, 31));
            hz.rs1_used_ID    = 1'($urandom_range(0, 1));
            hz.rs2_used_ID    = 1'($urandom_range(0, 1));
            hz.mem_r_EX       = 1'($urandom_range(0, 1));
            hz.redirect_EX    = ($urandom_range(0, 5) == 0);
            hz.exp_vector_MEM = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            hz.mret_MEM       = ($urandom_range(0, 11) == 0);
            hz.isFlushed_MEM  = ($urandom_range(0, 3) == 0);
            hz.dmem_busy      = ($urandom_range(0, 4) == 0);
        end
        tick();
        rst = 1'b0;
        idle();
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline latches: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Generates every latch EN/flush pair and the PC source select.
- Handles load-use stalls, taken-branch redirects, multi-cycle data-memory waits, and trap/mret redirects raised from the MEM stage.
- Keeps saturating stall/flush performance counters for the debug display.

Parameters:
- REDIRECT_BUBBLES, 1, extra fetch-hold cycles after a trap/mret redirect (0..15).
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-high reset
- rs1_ID  in  5  ID-stage source register 1
- rs2_ID  in  5  ID-stage source register 2
- rs1_used_ID  in  1  ID instruction reads rs1
- rs2_used_ID  in  1  ID instruction reads rs2
- rd_EX  in  5  EX-stage destination register
- mem_r_EX  in  1  EX-stage instruction is a load
- redirect_EX  in  1  taken branch/jump resolved in EX
- exp_vector_MEM  in  2  nonzero = exception pending on the MEM instruction
- mret_MEM  in  1  mret in MEM
- isFlushed_MEM  in  1  MEM slot holds a flushed bubble
- dmem_busy  in  1  data memory not ready this cycle
- en_IF  out  1  PC register enable
- en_IFID, flush_IFID  out  1 each  IF/ID latch control
- en_IDEX, flush_IDEX  out  1 each  ID/EX latch control
- en_EXMEM, flush_EXMEM  out  1 each  EX/MEM latch control
- en_MEMWB  out  1  MEM/WB latch enable
- pc_sel  out  2  PC source: 0 = PC+4, 1 = branch target, 2 = mtvec, 3 = mepc
- trap_commit  out  1  one-cycle pulse that tells the CSR unit to take the trap
- stall_cycles  out  CNT_W  saturating count of stalled cycles
- flush_events  out  CNT_W  saturating count of redirect events

Behaviour:
- State register: RUN, MEM_WAIT, REDIRECT, plus a 4-bit bubble counter.
- Outputs are combinational from state and inputs; state and counters are registered.
- Latch flush only takes effect with EN=1, so every asserted flush_X has its en_X=1.
- Default (RUN, no event): all en=1, all flush=0, pc_sel=0, trap_commit=0.
- Event priority in RUN, highest first:
  - trap: exp_vector_MEM!=0 && !isFlushed_MEM.
  - mret: mret_MEM && !isFlushed_MEM.
  - dmem_busy.
  - redirect_EX.
  - load-use.
- Trap/mret, detection cycle:
  - flush_IFID, flush_IDEX and flush_EXMEM all =1; en_MEMWB=1.
  - pc_sel = 2 for a trap, 3 for mret.
  - trap_commit=1 for a trap only.
  - flush_events increments.
  - Next state: REDIRECT with counter=REDIRECT_BUBBLES, or RUN if REDIRECT_BUBBLES=0.
  - A trap or mret in the same cycle as dmem_busy wins; that access is abandoned.
- dmem_busy in RUN:
  - All en=0 and all flush=0 that cycle; next state MEM_WAIT.
  - MEM_WAIT: all en=0 while dmem_busy=1.
  - First cycle with dmem_busy=0: outputs equal RUN defaults; next state RUN.
  - stall_cycles increments for every cycle with en_IF=0 caused by a memory wait.
- redirect_EX: flush_IFID=1, flush_IDEX=1, pc_sel=1, EX/MEM advances normally; flush_events increments.
  - Load-use in the same cycle is ignored, because the ID instruction is discarded.
- Load-use:
  - Condition: mem_r_EX && rd_EX!=0 && ((rs1_used_ID && rs1_ID==rd_EX) || (rs2_used_ID && rs2_ID==rd_EX)).
  - Response: en_IF=0, en_IFID=0, flush_IDEX=1, later stages advance.
  - Exactly one bubble per hazard, because the load leaves EX next cycle.
  - stall_cycles increments.
- REDIRECT:
  - en_IF=0, flush_IFID=1, rest advance, pc_sel=0.
  - Counter decrements each cycle; go to RUN when the counter reaches 1.
  - dmem_busy here freezes everything, counter included. stall_cycles increments.
  - Trap/mret are not re-checked here: MEM holds only bubbles.
- Counters saturate at all-ones and never wrap.
- Reset (asynchronous, any state, mid-operation included):
  - Return to RUN, bubble counter=0, both performance counters=0.
  - During reset, outputs show RUN defaults: en=1, flush=0, pc_sel=0, trap_commit=0.
- rd_EX==0 never causes a stall.

Decomposition:
- Shared package holds:
  - state encoding: RUN=2'd0, MEM_WAIT=2'd1, REDIRECT=2'd2.
  - PC_SEL_* constants 0..3.
- Sub-module: sat_counter, instanced twice for stall_cycles and flush_events.
- Hazard comparator stays inline.

Test Plan:
- Load-use: lw x5 in EX (mem_r_EX=1, rd_EX=5), ID reads rs1=5 -> one cycle with en_IF=0, en_IFID=0, flush_IDEX=1; next cycle all defaults; stall_cycles=1.
- Taken branch: redirect_EX=1 together with the load-use condition -> flush_IFID=1, flush_IDEX=1, pc_sel=1, no stall; flush_events=1.
- Memory wait: dmem_busy high for 3 cycles -> all en=0 for exactly 3 cycles, state MEM_WAIT, resume on the 4th cycle; stall_cycles=3.
- Trap with REDIRECT_BUBBLES=2: exp_vector_MEM=2'b01, isFlushed_MEM=0 -> trap_commit=1 and pc_sel=2 for one cycle, flushes asserted, then 2 cycles of en_IF=0, then RUN.
  - The same stimulus with isFlushed_MEM=1 produces no trap.
- Trap with dmem_busy simultaneous: trap wins (pc_sel=2); an mret case gives pc_sel=3 with trap_commit=0.
- Reset mid-REDIRECT, plus saturation: assert rst -> RUN defaults immediately and counters=0; with CNT_W=4, 20 stall cycles -> stall_cycles=15.
